// File: rtl/coin_acceptor.sv
// Coin acceptor: sync + debounce of the coin slot sensor, coin classing,
// valid/ack hand-off of one coin value per insertion, reject and jam flags.
// Ports:
//   clk, nrst           clock, async active-low reset
//   coin_sense          raw slot sensor (high while coin present)
//   coin_type[1:0]      raw classifier code (00 nickel, 01 dime, 10 quarter)
//   coin_ack            consumer takes the presented coin
//   coin_valid          coin_value holds a coin awaiting ack
//   coin_value[VAL_W]   value of the presented coin
//   coin_reject         one-cycle pulse for an invalid coin (type 11)
//   jam                 coin stuck in the slot
module coin_acceptor #(
   parameter int VAL_W      = 8,
   parameter int DEB_CYCLES = 4,
   parameter int JAM_CYCLES = 1000,
   parameter int NICKEL     = 5,
   parameter int DIME       = 10,
   parameter int QUARTER    = 25
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             coin_sense,
   input  logic [1:0]       coin_type,
   input  logic             coin_ack,
   output logic             coin_valid,
   output logic [VAL_W-1:0] coin_value,
   output logic             coin_reject,
   output logic             jam
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int JW = $clog2(JAM_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);
   localparam logic [JW-1:0] JAM_MAX = JW'(JAM_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      DEB_IN,
      PRESENT,
      WAIT_REL
   } state_t;

   state_t state_q, state_d;

   logic sense_m_q, sense_s_q;
   logic [1:0] type_m_q, type_s_q;

   logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_inc;
   logic [JW-1:0] jam_cnt_q, jam_cnt_d;
   logic valid_q, valid_d;
   logic [VAL_W-1:0] value_q, value_d;
   logic reject_q, reject_d;
   logic jam_q, jam_d;
   logic take;
   logic jam_inc;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sense_m_q <= 1'b0;
         sense_s_q <= 1'b0;
         type_m_q  <= 2'b00;
         type_s_q  <= 2'b00;
         state_q   <= IDLE;
         deb_cnt_q <= '0;
         jam_cnt_q <= '0;
         valid_q   <= 1'b0;
         value_q   <= '0;
         reject_q  <= 1'b0;
         jam_q     <= 1'b0;
      end else begin
         sense_m_q <= coin_sense;
         sense_s_q <= sense_m_q;
         type_m_q  <= coin_type;
         type_s_q  <= type_m_q;
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
         jam_cnt_q <= jam_cnt_d;
         valid_q   <= valid_d;
         value_q   <= value_d;
         reject_q  <= reject_d;
         jam_q     <= jam_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      jam_cnt_d = jam_cnt_q;
      valid_d   = valid_q;
      value_d   = value_q;
      reject_d  = 1'b0;
      take      = 1'b0;
      deb_inc   = deb_cnt_q + 1'b1;
      jam_inc   = sense_s_q && (jam_cnt_q != JAM_MAX);

      unique case (state_q)
         IDLE: begin
            if (sense_s_q) begin
               state_d   = DEB_IN;
               deb_cnt_d = DW'(1);
               // With a one-cycle debounce the first sample already qualifies.
               take      = (DEB_MAX == DW'(1));
            end
         end
         DEB_IN: begin
            if (!sense_s_q) begin
               state_d   = IDLE;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_inc;
               take      = (deb_inc == DEB_MAX);
            end
         end
         PRESENT: begin
            if (jam_inc) jam_cnt_d = jam_cnt_q + 1'b1;
            if (coin_ack) begin
               valid_d   = 1'b0;
               state_d   = WAIT_REL;
               deb_cnt_d = '0;
            end
         end
         WAIT_REL: begin
            if (jam_inc) jam_cnt_d = jam_cnt_q + 1'b1;
            if (sense_s_q) begin
               deb_cnt_d = '0;
            end else if (deb_inc == DEB_MAX) begin
               state_d   = IDLE;
               deb_cnt_d = '0;
               jam_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Debounce complete: classify the latched coin type.
      if (take) begin
         deb_cnt_d = '0;
         jam_cnt_d = '0;
         unique case (type_s_q)
            2'b00: begin
               value_d = VAL_W'(NICKEL);
               valid_d = 1'b1;
               state_d = PRESENT;
            end
            2'b01: begin
               value_d = VAL_W'(DIME);
               valid_d = 1'b1;
               state_d = PRESENT;
            end
            2'b10: begin
               value_d = VAL_W'(QUARTER);
               valid_d = 1'b1;
               state_d = PRESENT;
            end
            default: begin
               reject_d = 1'b1;
               state_d  = WAIT_REL;
            end
         endcase
      end

      // Saturated count holds jam; re-entering IDLE clears the count.
      jam_d = (jam_cnt_d == JAM_MAX);
   end

   assign coin_valid  = valid_q;
   assign coin_value  = value_q;
   assign coin_reject = reject_q;
   assign jam         = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: latency, glitch, reject, hold,
// jam, async reset and back-to-back insertion scenarios.
module tb_coin_acceptor;

   logic clk;
   logic nrst;
   logic coin_sense;
   logic [1:0] coin_type;
   logic coin_ack;
   logic coin_valid;
   logic [7:0] coin_value;
   logic coin_reject;
   logic jam;

   int total;
   int bad;
   int acc_cnt;
   int rise_cnt;
   int rej_cyc;
   logic valid_prev;

   coin_acceptor #(
      .VAL_W(8),
      .DEB_CYCLES(4),
      .JAM_CYCLES(30),
      .NICKEL(5),
      .DIME(10),
      .QUARTER(25)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .coin_sense(coin_sense),
      .coin_type(coin_type),
      .coin_ack(coin_ack),
      .coin_valid(coin_valid),
      .coin_value(coin_value),
      .coin_reject(coin_reject),
      .jam(jam)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      acc_cnt = 0;
      rise_cnt = 0;
      rej_cyc = 0;
      valid_prev = 1'b0;
   end

   always @(posedge clk) begin
      if (coin_valid && coin_ack) acc_cnt <= acc_cnt + 1;
      if (coin_valid && !valid_prev) rise_cnt <= rise_cnt + 1;
      if (coin_reject) rej_cyc <= rej_cyc + 1;
      valid_prev <= coin_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   int a0, r0, j0, hb;

   initial begin
      total = 0;
      bad = 0;
      nrst = 1'b0;
      coin_sense = 1'b0;
      coin_type = 2'b00;
      coin_ack = 1'b0;
      cyc(3);
      chk("rst_valid", {31'd0, coin_valid}, 0);
      chk("rst_value", {24'd0, coin_value}, 0);
      chk("rst_reject", {31'd0, coin_reject}, 0);
      chk("rst_jam", {31'd0, jam}, 0);
      nrst = 1'b1;
      cyc(3);

      // 1: dime, latency 6 edges, single acceptance
      a0 = acc_cnt;
      coin_type = 2'b01;
      coin_sense = 1'b1;
      cyc(5);
      chk("t1_pre", {31'd0, coin_valid}, 0);
      cyc(1);
      chk("t1_valid", {31'd0, coin_valid}, 1);
      chk("t1_value", {24'd0, coin_value}, 10);
      cyc(2);
      coin_ack = 1'b1;
      cyc(1);
      coin_ack = 1'b0;
      chk("t1_clr", {31'd0, coin_valid}, 0);
      cyc(11);
      coin_sense = 1'b0;
      cyc(10);
      chk("t1_acc", acc_cnt - a0, 1);
      chk("t1_jam", {31'd0, jam}, 0);

      // 2: glitch, plus a stray ack while nothing is valid
      a0 = acc_cnt;
      r0 = rise_cnt;
      j0 = rej_cyc;
      coin_type = 2'b00;
      coin_sense = 1'b1;
      cyc(2);
      coin_sense = 1'b0;
      coin_ack = 1'b1;
      cyc(2);
      coin_ack = 1'b0;
      cyc(8);
      chk("t2_rise", rise_cnt - r0, 0);
      chk("t2_rej", rej_cyc - j0, 0);
      chk("t2_acc", acc_cnt - a0, 0);

      // 3: invalid type 11
      r0 = rise_cnt;
      j0 = rej_cyc;
      coin_type = 2'b11;
      coin_sense = 1'b1;
      cyc(5);
      chk("t3_pre", {31'd0, coin_reject}, 0);
      cyc(1);
      chk("t3_pulse", {31'd0, coin_reject}, 1);
      chk("t3_value", {24'd0, coin_value}, 10);
      cyc(1);
      chk("t3_post", {31'd0, coin_reject}, 0);
      cyc(3);
      coin_sense = 1'b0;
      cyc(10);
      chk("t3_rejcyc", rej_cyc - j0, 1);
      chk("t3_rise", rise_cnt - r0, 0);

      // 4: quarter, ack withheld 50 cycles
      a0 = acc_cnt;
      coin_type = 2'b10;
      coin_sense = 1'b1;
      cyc(6);
      chk("t4_valid", {31'd0, coin_valid}, 1);
      chk("t4_value", {24'd0, coin_value}, 25);
      hb = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1);
         if (!coin_valid || coin_value != 8'd25) hb++;
      end
      chk("t4_hold", hb, 0);
      coin_ack = 1'b1;
      cyc(1);
      coin_ack = 1'b0;
      chk("t4_clr", {31'd0, coin_valid}, 0);
      coin_sense = 1'b0;
      cyc(10);
      chk("t4_acc", acc_cnt - a0, 1);
      chk("t4_jamclr", {31'd0, jam}, 0);

      // 5: nickel held 100 cycles, jam after 30 post-accept cycles
      coin_type = 2'b00;
      coin_sense = 1'b1;
      cyc(6);
      chk("t5_valid", {31'd0, coin_valid}, 1);
      cyc(29);
      chk("t5_nojam", {31'd0, jam}, 0);
      cyc(1);
      chk("t5_jam", {31'd0, jam}, 1);
      chk("t5_keep", {31'd0, coin_valid}, 1);
      coin_ack = 1'b1;
      cyc(1);
      coin_ack = 1'b0;
      cyc(63);
      chk("t5_jamhold", {31'd0, jam}, 1);
      coin_sense = 1'b0;
      cyc(5);
      chk("t5_jamrel", {31'd0, jam}, 1);
      cyc(1);
      chk("t5_jamoff", {31'd0, jam}, 0);
      cyc(4);

      // 6: async reset while valid
      coin_type = 2'b01;
      coin_sense = 1'b1;
      cyc(6);
      chk("t6_valid", {31'd0, coin_valid}, 1);
      #2 nrst = 1'b0;
      #1;
      chk("t6_rvalid", {31'd0, coin_valid}, 0);
      chk("t6_rvalue", {24'd0, coin_value}, 0);
      chk("t6_rrej", {31'd0, coin_reject}, 0);
      chk("t6_rjam", {31'd0, jam}, 0);
      cyc(1);
      coin_sense = 1'b0;
      cyc(3);
      nrst = 1'b1;
      cyc(2);
      coin_type = 2'b10;
      coin_sense = 1'b1;
      cyc(5);
      chk("t6_pre", {31'd0, coin_valid}, 0);
      cyc(1);
      chk("t6_valid2", {31'd0, coin_valid}, 1);
      chk("t6_value2", {24'd0, coin_value}, 25);
      coin_ack = 1'b1;
      cyc(1);
      coin_ack = 1'b0;
      coin_sense = 1'b0;
      cyc(10);

      // 7a: short 2-cycle gap does not release
      a0 = acc_cnt;
      r0 = rise_cnt;
      coin_type = 2'b00;
      coin_sense = 1'b1;
      cyc(6);
      coin_ack = 1'b1;
      cyc(1);
      coin_ack = 1'b0;
      cyc(3);
      coin_sense = 1'b0;
      cyc(2);
      coin_sense = 1'b1;
      cyc(10);
      chk("t7a_valid", {31'd0, coin_valid}, 0);
      coin_sense = 1'b0;
      cyc(10);
      chk("t7a_acc", acc_cnt - a0, 1);
      chk("t7a_rise", rise_cnt - r0, 1);

      // 7b: 6-cycle gap gives two acceptances
      a0 = acc_cnt;
      coin_sense = 1'b1;
      cyc(6);
      chk("t7b_v1", {24'd0, coin_value}, 5);
      coin_ack = 1'b1;
      cyc(1);
      coin_ack = 1'b0;
      cyc(3);
      coin_sense = 1'b0;
      cyc(6);
      coin_sense = 1'b1;
      cyc(6);
      chk("t7b_valid2", {31'd0, coin_valid}, 1);
      chk("t7b_v2", {24'd0, coin_value}, 5);
      coin_ack = 1'b1;
      cyc(1);
      coin_ack = 1'b0;
      coin_sense = 1'b0;
      cyc(10);
      chk("t7b_acc", acc_cnt - a0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
